pc_fetch: RTL and testbench
===========================

# pc_fetch

Fetch stage of the 3-stage RISC-V CPU (Fetch / Execute / Writeback). It owns the program counter, drives the synchronous instruction ROM, and presents the instruction, its PC and a valid bit to the EX stage, where the control unit decodes it. It consumes the EX-stage `pcsrc` decision, together with operands, to perform sequential, branch, JAL and JALR redirects. Each taken redirect squashes the one wrong-path fetch with a single-cycle bubble.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `ADDR_W`, 12, instruction ROM word-address width (depth 2^ADDR_W words)

Ports:
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — asynchronous, active-high reset
- `stall_EX` input 1 — EX cannot retire this cycle; freeze PC, ROM and EX registers
- `pcsrc_EX` input 2 — 00 sequential, 01 branch, 10 JAL, 11 JALR
- `branch_taken_EX` input 1 — ALU compare result; only meaningful when `pcsrc_EX`=01
- `imm_EX` input 32 — sign-extended B-, J- or I-immediate selected for the EX instruction
- `rs1_EX` input 32 — rs1 value for JALR
- `imem_addr` output ADDR_W — word address, equal to `pc_F[ADDR_W+1:2]`
- `imem_en` output 1 — ROM read enable, equal to `~stall_EX`
- `imem_rdata` input 32 — ROM output, registered inside the ROM one cycle after the address
- `instruction_EX` output 32 — `imem_rdata` when `valid_EX`=1, else NOP 32'h0000_0013
- `pc_EX` output 32 — PC of the instruction in EX
- `pc_plus4_EX` output 32 — `pc_EX`+4, used as the link value for JAL/JALR
- `valid_EX` output 1 — EX holds a real instruction, not a bubble
- `misalign_err` output 1 — sticky flag: a redirect target had bit 1 set

## Operation
- Internal state:
  - `pc_F` (32), the address currently presented to the ROM
  - `pc_EX`, `valid_EX`, `misalign_err`
- Redirect condition: `redirect` = `valid_EX` & ~`stall_EX` & (`pcsrc_EX`=10 | `pcsrc_EX`=11 | (`pcsrc_EX`=01 & `branch_taken_EX`)).
- Targets, computed combinationally in 32-bit arithmetic with wrap modulo 2^32:
  - Branch and JAL: `pc_EX`+`imm_EX`
  - JALR: (`rs1_EX`+`imm_EX`) & ~32'h1
- Misaligned targets: if target[1] is 1, set `misalign_err` (held until reset) and redirect to {target[31:2],2'b00}.
- Per clock edge, in priority order:
  1. `rst`: `pc_F`=`RESET_PC`, `pc_EX`=0, `valid_EX`=0, `misalign_err`=0; `instruction_EX` therefore reads NOP.
  2. `stall_EX`=1: hold every register. `imem_en`=0 holds the ROM output. Redirect is suppressed even if `pcsrc_EX` requests one.
  3. `redirect`: `pc_F`←target, `pc_EX`←`pc_F`, `valid_EX`←0. The wrong-path instruction fetched this cycle is squashed.
  4. Otherwise: `pc_F`←`pc_F`+4, `pc_EX`←`pc_F`, `valid_EX`←1.
- `pcsrc_EX`=01 with `branch_taken_EX`=0 behaves as sequential.
- `pcsrc_EX`, `branch_taken_EX` and operands are ignored while `valid_EX`=0, so a bubble never redirects.
- `imem_addr` wraps naturally at 2^ADDR_W words. No range error is raised.

## Timing
- Reset values:
  - `pc_F`=`RESET_PC`, so `imem_addr`=`RESET_PC[ADDR_W+1:2]`
  - `valid_EX`=0, `pc_EX`=0, `pc_plus4_EX`=4
  - `instruction_EX`=32'h0000_0013
  - `misalign_err`=0
  - `imem_en`=~`stall_EX`
- First edge after `rst` falls: `valid_EX`=1, `pc_EX`=`RESET_PC`, `pc_F`=`RESET_PC`+4. Fetch-to-EX latency is 1 cycle.
- Throughput: 1 instruction per cycle when there is no stall and no redirect.
- Taken redirect costs exactly 1 bubble cycle: the target instruction is valid in EX 2 edges after the redirect edge's EX cycle began.
- Back-to-back redirects cannot occur, because the cycle after any redirect is always a bubble.
- `rst` asserted mid-stall or mid-redirect: the asynchronous clear wins immediately, and the outputs take their reset values without waiting for a clock.
- All outputs except `imem_addr`, `imem_en`, `instruction_EX` and `pc_plus4_EX` are direct register outputs. Those four are derived combinationally from registers or `stall_EX` only.

## Test plan
- Reset then free-run with ROM filled by ADDIs, `RESET_PC`=0 → `pc_EX` steps 0,4,8,12; `valid_EX`=1 from the first edge on; `instruction_EX`=NOP while in reset.
- Taken BEQ at `pc_EX`=0x10 with `imm_EX`=0xFFFF_FFF8 → next cycle `valid_EX`=0 and NOP; following cycle `pc_EX`=0x08, `valid_EX`=1.
- Not-taken branch (`pcsrc_EX`=01, `branch_taken_EX`=0) at 0x10 → no bubble; `pc_EX`=0x14 next.
- JALR with `rs1_EX`=0x103, `imm_EX`=0 → target 0x102: `misalign_err`=1, fetch resumes at 0x100 after one bubble; `pc_plus4_EX` at the JALR cycle = `pc_EX`+4.
- `stall_EX`=1 for 3 cycles while `pcsrc_EX`=10 → `pc_F`, `pc_EX` and `instruction_EX` are frozen; the JAL redirect happens on the first unstalled edge.
- Assert `rst` asynchronously between edges during a redirect bubble → outputs return to reset values immediately; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/pc_fetch.sv
// pc_fetch: RISC-V fetch stage owning the PC, driving the sync ROM and redirecting on branch/JAL/JALR
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_EX,
    input  logic [1:0]        pcsrc_EX,
    input  logic              branch_taken_EX,
    input  logic [31:0]       imm_EX,
    input  logic [31:0]       rs1_EX,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction_EX,
    output logic [31:0]       pc_EX,
    output logic [31:0]       pc_plus4_EX,
    output logic              valid_EX,
    output logic              misalign_err
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic [31:0] pc_F;
    logic [31:0] tgt_raw;
    logic [31:0] tgt;
    logic        redirect;
    // Redirect decision and target; bubbles never redirect, bit 1 of a bad target is forced to word alignment
    always_comb begin
        redirect = valid_EX & ~stall_EX & (pcsrc_EX[1] | (pcsrc_EX == 2'b01 & branch_taken_EX));
        tgt_raw  = (pcsrc_EX == 2'b11) ? ((rs1_EX + imm_EX) & ~32'h1) : (pc_EX + imm_EX);
        tgt      = tgt_raw[1] ? {tgt_raw[31:2], 2'b00} : tgt_raw;
    end
    assign imem_addr      = pc_F[ADDR_W+1:2];
    assign imem_en        = ~stall_EX;
    assign instruction_EX = valid_EX ? imem_rdata : NOP;
    assign pc_plus4_EX    = pc_EX + 32'd4;
    // PC and EX-stage registers: stall holds, redirect squashes the wrong-path fetch, otherwise advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_F         <= RESET_PC;
            pc_EX        <= 32'h0;
            valid_EX     <= 1'b0;
            misalign_err <= 1'b0;
        end else if (!stall_EX) begin
            pc_EX        <= pc_F;
            pc_F         <= redirect ? tgt : pc_F + 32'd4;
            valid_EX     <= ~redirect;
            misalign_err <= misalign_err | (redirect & tgt_raw[1]);
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed bench with a cycle-level reference model and per-cycle output comparison
module tb_pc_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_EX = 1'b0;
    logic [1:0]  pcsrc_EX = 2'b00;
    logic        branch_taken_EX = 1'b0;
    logic [31:0] imm_EX = 32'h0;
    logic [31:0] rs1_EX = 32'h0;
    logic [11:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_EX;
    logic [31:0] pc_EX;
    logic [31:0] pc_plus4_EX;
    logic        valid_EX;
    logic        misalign_err;
    int          n_vec = 0;
    int          n_err = 0;
    bit          cmp_en = 1'b0;
    logic [31:0] m_pcf, m_pce;
    logic        m_valid, m_mis;

    pc_fetch #(.RESET_PC(32'h0), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .stall_EX(stall_EX), .pcsrc_EX(pcsrc_EX),
        .branch_taken_EX(branch_taken_EX), .imm_EX(imm_EX), .rs1_EX(rs1_EX),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
        .instruction_EX(instruction_EX), .pc_EX(pc_EX), .pc_plus4_EX(pc_plus4_EX),
        .valid_EX(valid_EX), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // ROM word at word address a: ADDI x1, x0, a
    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return {a, 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    always @(posedge clk) if (imem_en) imem_rdata <= rom_word(imem_addr);

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    // Reference model: what the fetch stage must hold after each edge
    always @(posedge clk or posedge rst) begin
        logic        take;
        logic [31:0] t;
        if (rst) begin
            m_pcf   <= 32'h0;
            m_pce   <= 32'h0;
            m_valid <= 1'b0;
            m_mis   <= 1'b0;
        end else if (!stall_EX) begin
            take = m_valid && (pcsrc_EX == 2'd2 || pcsrc_EX == 2'd3 || (pcsrc_EX == 2'd1 && branch_taken_EX));
            t = (pcsrc_EX == 2'd3) ? ((rs1_EX + imm_EX) & 32'hFFFF_FFFE) : (m_pce + imm_EX);
            m_pce   <= m_pcf;
            m_valid <= !take;
            if (take && t[1]) m_mis <= 1'b1;
            m_pcf   <= take ? (t[1] ? (t & 32'hFFFF_FFFC) : t) : m_pcf + 32'd4;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) if (cmp_en) begin
        chk("imem_addr", {20'h0, imem_addr}, {20'h0, m_pcf[13:2]});
        chk("imem_en", {31'h0, imem_en}, {31'h0, ~stall_EX});
        chk("pc_EX", pc_EX, m_pce);
        chk("pc_plus4_EX", pc_plus4_EX, m_pce + 32'd4);
        chk("valid_EX", {31'h0, valid_EX}, {31'h0, m_valid});
        chk("misalign_err", {31'h0, misalign_err}, {31'h0, m_mis});
        chk("instruction_EX", instruction_EX, m_valid ? rom_word(m_pce[13:2]) : 32'h0000_0013);
    end

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) cyc;
        chk("rst_valid", {31'h0, valid_EX}, 32'h0);
        chk("rst_instr", instruction_EX, 32'h0000_0013);
        chk("rst_pc_EX", pc_EX, 32'h0);
        chk("rst_pc_plus4", pc_plus4_EX, 32'h4);
        chk("rst_imem_addr", {20'h0, imem_addr}, 32'h0);
        chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
        cmp_en = 1'b1;
        rst = 1'b0;
        cyc;
        chk("first_pc", pc_EX, 32'h0);
        chk("first_valid", {31'h0, valid_EX}, 32'h1);
        chk("first_instr", instruction_EX, 32'h0000_0093);
        cyc; chk("pc4", pc_EX, 32'h4);
        cyc; chk("pc8", pc_EX, 32'h8);
        cyc; chk("pc12", pc_EX, 32'hC);
        cyc; chk("pc16", pc_EX, 32'h10);
        pcsrc_EX = 2'b01; branch_taken_EX = 1'b1; imm_EX = 32'hFFFF_FFF8;
        cyc;
        chk("beq_bubble_valid", {31'h0, valid_EX}, 32'h0);
        chk("beq_bubble_instr", instruction_EX, 32'h0000_0013);
        cyc;
        chk("beq_target_pc", pc_EX, 32'h8);
        chk("beq_target_valid", {31'h0, valid_EX}, 32'h1);
        pcsrc_EX = 2'b00; branch_taken_EX = 1'b0; imm_EX = 32'h0;
        cyc; cyc;
        chk("nt_at_16", pc_EX, 32'h10);
        pcsrc_EX = 2'b01; branch_taken_EX = 1'b0; imm_EX = 32'h40;
        cyc;
        chk("nt_next_pc", pc_EX, 32'h14);
        chk("nt_next_valid", {31'h0, valid_EX}, 32'h1);
        pcsrc_EX = 2'b11; rs1_EX = 32'h103; imm_EX = 32'h0;
        #1 chk("jalr_link", pc_plus4_EX, 32'h18);
        cyc;
        chk("jalr_misalign", {31'h0, misalign_err}, 32'h1);
        chk("jalr_bubble", {31'h0, valid_EX}, 32'h0);
        pcsrc_EX = 2'b00; rs1_EX = 32'h0;
        cyc;
        chk("jalr_target", pc_EX, 32'h100);
        pcsrc_EX = 2'b10; imm_EX = 32'h20; stall_EX = 1'b1;
        repeat (3) begin
            cyc;
            chk("stall_pc_EX", pc_EX, 32'h100);
            chk("stall_imem_addr", {20'h0, imem_addr}, 32'h41);
            chk("stall_instr", instruction_EX, rom_word(12'h40));
        end
        stall_EX = 1'b0;
        cyc;
        chk("jal_bubble", {31'h0, valid_EX}, 32'h0);
        chk("jal_bubble_pc", pc_EX, 32'h104);
        cyc;
        chk("jal_target", pc_EX, 32'h120);
        chk("jal_target_valid", {31'h0, valid_EX}, 32'h1);
        pcsrc_EX = 2'b00; imm_EX = 32'h0;
        cyc;
        pcsrc_EX = 2'b10; imm_EX = 32'h40;
        cyc;
        chk("pre_rst_bubble", {31'h0, valid_EX}, 32'h0);
        #1 rst = 1'b1;
        #1;
        chk("arst_pc_EX", pc_EX, 32'h0);
        chk("arst_valid", {31'h0, valid_EX}, 32'h0);
        chk("arst_misalign", {31'h0, misalign_err}, 32'h0);
        chk("arst_imem_addr", {20'h0, imem_addr}, 32'h0);
        chk("arst_instr", instruction_EX, 32'h0000_0013);
        pcsrc_EX = 2'b00; imm_EX = 32'h0;
        cyc;
        rst = 1'b0;
        cyc;
        chk("restart_pc", pc_EX, 32'h0);
        chk("restart_valid", {31'h0, valid_EX}, 32'h1);
        cyc;
        chk("restart_pc4", pc_EX, 32'h4);
        stall_EX = 1'b1;
        cyc;
        stall_EX = 1'b0;
        repeat (4) cyc;
        chk("after_stall_pc", pc_EX, 32'h14);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
